teensy_packet_framer: RTL and testbench

Multi-channel successor to the single-axis Teensy link framer: on each extraction trigger it snapshots a frame counter and `NUM_CH` position words, then serialises them as a byte stream (header, frame number, per-channel positions, 8-bit checksum) to the RS-232C byte transmitter through a valid/ready handshake. It sits between the position calculators and `rs232c_transmitter` and replaces the fixed 9-byte packet generator. It also reports overruns when triggers arrive faster than packets drain.

---
 rtl/teensy_packet_framer_pkg.sv | 22 ++
 rtl/teensy_packet_framer_if.sv | 9 +
 rtl/teensy_packet_framer_byte_mux.sv | 38 +++
 rtl/teensy_packet_framer.sv | 151 +++++++++++++++
 tb/tb_teensy_packet_framer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/teensy_packet_framer_pkg.sv
// rtl/teensy_packet_framer_pkg.sv - shared types and constants for the Teensy link framer
package teensy_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_FRM,
    ST_POS,
    ST_CHK
  } framer_state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hFF;

  // Filter modes of the position calculators, shared with their consumers.
  localparam logic [1:0] MODE_NO_FILTERING = 2'd0;
  localparam logic [1:0] MODE_FILTERING    = 2'd1;
  localparam logic [1:0] MODE_REMOVE_DRIFT = 2'd2;

  localparam int BYTE_IDX_W = 2;
  localparam int CH_IDX_W   = 3;

endpackage

// File: rtl/teensy_packet_framer_if.sv
// rtl/teensy_packet_framer_if.sv - byte stream handshake toward the RS-232C transmitter
interface teensy_packet_framer_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/teensy_packet_framer_byte_mux.sv
// rtl/teensy_packet_framer_byte_mux.sv - selects the packet byte for a given state and index
module packet_byte_mux
  import teensy_if_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         NUM_CH      = 2,
  parameter int         FRAME_BYTES = 4,
  parameter int         POSTI_BYTES = 4
) (
  input  framer_state_t                       state_i,
  input  logic [BYTE_IDX_W-1:0]               byte_idx_i,
  input  logic [CH_IDX_W-1:0]                 ch_idx_i,
  input  logic [FRAME_BYTES*8-1:0]            frame_i,
  input  logic [NUM_CH*POSTI_BYTES*8-1:0]     posti_i,
  input  logic [7:0]                          csum_i,
  output logic [7:0]                          byte_o
);

  logic [31:0]                      pos_off;
  logic [FRAME_BYTES*8-1:0]         frame_sh;
  logic [NUM_CH*POSTI_BYTES*8-1:0]  posti_sh;

  assign pos_off  = (32'(ch_idx_i) * 32'(POSTI_BYTES) + 32'(byte_idx_i)) * 32'd8;
  assign frame_sh = frame_i >> {byte_idx_i, 3'b000};
  assign posti_sh = posti_i >> pos_off;

  always_comb begin
    byte_o = 8'h00;
    case (state_i)
      ST_HDR:  byte_o = HEADER;
      ST_FRM:  byte_o = frame_sh[7:0];
      ST_POS:  byte_o = posti_sh[7:0];
      ST_CHK:  byte_o = csum_i;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/teensy_packet_framer.sv
// rtl/teensy_packet_framer.sv - snapshots frame/position words and streams them as a checksummed packet
module teensy_packet_framer
  import teensy_if_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         NUM_CH      = 2,
  parameter int         FRAME_BYTES = 4,
  parameter int         POSTI_BYTES = 4,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [FRAME_BYTES*8-1:0]          frame_num,
  input  logic [NUM_CH*POSTI_BYTES*8-1:0]   posti_data,
  teensy_packet_framer_if.master            tx,
  output logic                              busy,
  output logic                              pkt_done,
  output logic [15:0]                       overrun_cnt
);

  localparam logic [BYTE_IDX_W-1:0] FRM_LAST = BYTE_IDX_W'(FRAME_BYTES - 1);
  localparam logic [BYTE_IDX_W-1:0] POS_LAST = BYTE_IDX_W'(POSTI_BYTES - 1);
  localparam logic [CH_IDX_W-1:0]   CH_LAST  = CH_IDX_W'(NUM_CH - 1);

  framer_state_t                    state_q, state_d;
  logic [BYTE_IDX_W-1:0]            byte_idx_q, byte_idx_d;
  logic [CH_IDX_W-1:0]              ch_idx_q, ch_idx_d;
  logic [FRAME_BYTES*8-1:0]         frame_q, frame_d;
  logic [NUM_CH*POSTI_BYTES*8-1:0]  posti_q, posti_d;
  logic [7:0]                       csum_q, csum_d;
  logic                             tx_valid_q, tx_valid_d;
  logic [7:0]                       tx_data_q, tx_data_d;
  logic                             pkt_done_q, pkt_done_d;
  logic [15:0]                      overrun_q, overrun_d;
  logic                             accept;
  logic [7:0]                       mux_byte;

  assign accept = tx_valid_q & tx.tx_ready;

  // Fed with next-state indices so tx_data is registered alongside the state it belongs to.
  packet_byte_mux #(
    .HEADER      (HEADER),
    .NUM_CH      (NUM_CH),
    .FRAME_BYTES (FRAME_BYTES),
    .POSTI_BYTES (POSTI_BYTES)
  ) u_mux (
    .state_i    (state_d),
    .byte_idx_i (byte_idx_d),
    .ch_idx_i   (ch_idx_d),
    .frame_i    (frame_q),
    .posti_i    (posti_q),
    .csum_i     (csum_d),
    .byte_o     (mux_byte)
  );

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    ch_idx_d   = ch_idx_q;
    frame_d    = frame_q;
    posti_d    = posti_q;
    csum_d     = csum_q;
    pkt_done_d = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_HDR;
        byte_idx_d = '0;
        ch_idx_d   = '0;
        csum_d     = 8'h00;
        frame_d    = frame_num;
        posti_d    = posti_data;
      end
      ST_HDR: if (accept) begin
        state_d    = ST_FRM;
        byte_idx_d = '0;
      end
      ST_FRM: if (accept) begin
        csum_d = csum_q + tx_data_q;
        if (byte_idx_q == FRM_LAST) begin
          state_d    = ST_POS;
          byte_idx_d = '0;
          ch_idx_d   = '0;
        end else begin
          byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
        end
      end
      ST_POS: if (accept) begin
        csum_d = csum_q + tx_data_q;
        if (byte_idx_q == POS_LAST) begin
          byte_idx_d = '0;
          if (ch_idx_q == CH_LAST) begin
            state_d    = CHECKSUM_EN ? ST_CHK : ST_IDLE;
            pkt_done_d = !CHECKSUM_EN;
          end else begin
            ch_idx_d = ch_idx_q + CH_IDX_W'(1);
          end
        end else begin
          byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
        end
      end
      ST_CHK: if (accept) begin
        state_d    = ST_IDLE;
        pkt_done_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_IDLE) && (overrun_q != 16'hFFFF)) begin
      overrun_d = overrun_q + 16'd1;
    end

    tx_valid_d = (state_d != ST_IDLE);
    tx_data_d  = mux_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      ch_idx_q   <= '0;
      frame_q    <= '0;
      posti_q    <= '0;
      csum_q     <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      pkt_done_q <= 1'b0;
      overrun_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      ch_idx_q   <= ch_idx_d;
      frame_q    <= frame_d;
      posti_q    <= posti_d;
      csum_q     <= csum_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      pkt_done_q <= pkt_done_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign pkt_done    = pkt_done_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_teensy_packet_framer.sv
// tb/tb_teensy_packet_framer.sv - directed self-checking bench for teensy_packet_framer
module tb_teensy_packet_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start_a = 1'b0;
  logic [31:0] frame_a = '0;
  logic [63:0] posti_a = '0;
  logic        busy_a, done_a;
  logic [15:0] ovr_a;

  logic        start_b = 1'b0;
  logic [15:0] frame_b = '0;
  logic [7:0]  posti_b = '0;
  logic        busy_b, done_b;
  logic [15:0] ovr_b;

  int tests = 0;
  int fails = 0;

  teensy_packet_framer_if ifa ();
  teensy_packet_framer_if ifb ();

  always #5 clk = ~clk;

  teensy_packet_framer #(
    .NUM_CH(2), .FRAME_BYTES(4), .POSTI_BYTES(4), .CHECKSUM_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .frame_num(frame_a), .posti_data(posti_a),
    .tx(ifa), .busy(busy_a), .pkt_done(done_a), .overrun_cnt(ovr_a)
  );

  teensy_packet_framer #(
    .NUM_CH(1), .FRAME_BYTES(2), .POSTI_BYTES(1), .CHECKSUM_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .frame_num(frame_b), .posti_data(posti_b),
    .tx(ifb), .busy(busy_b), .pkt_done(done_b), .overrun_cnt(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams one 14-byte packet out of dut_a, optionally injecting triggers while it is busy.
  task automatic run_a(input bit do_start, input int rdy_pct, input int inj_mid, input bit inj_last,
                       input bit start_at_done, input int stop_after,
                       input logic [31:0] fr, input logic [63:0] pd, input logic [111:0] exp);
    int         iter = 0;
    int         hold_err = 0;
    int         target;
    bit         pv = 1'b0;
    bit         pr = 1'b0;
    bit         rdy;
    logic [7:0] pdat = 8'h00;
    logic [7:0] got[$];
    target = (stop_after != 0) ? stop_after : 14;
    if (do_start) begin
      @(negedge clk);
      frame_a = fr;
      posti_a = pd;
      start_a = 1'b1;
    end
    while (1) begin
      @(negedge clk);
      iter++;
      start_a = 1'b0;
      if (iter > 400) begin
        check("a_timeout", 32'(got.size()), 32'(target));
        break;
      end
      if ((iter == 2 && inj_mid >= 1) || (iter == 4 && inj_mid >= 2) || (iter == 6 && inj_mid >= 3)) begin
        start_a = 1'b1;
        frame_a = 32'hDEADBEEF;
        posti_a = 64'h5555_5555_AAAA_AAAA;
      end
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (pv && !pr && !(ifa.tx_valid === 1'b1 && ifa.tx_data === pdat)) hold_err++;
      if (ifa.tx_valid === 1'b1 && rdy) begin
        got.push_back(ifa.tx_data);
        if (got.size() == 14 && inj_last) start_a = 1'b1;
      end
      ifa.tx_ready = rdy;
      pv   = ifa.tx_valid;
      pr   = rdy;
      pdat = ifa.tx_data;
      if (got.size() == target) break;
    end
    check("a_hold", 32'(hold_err), 32'd0);
    for (int i = 0; i < got.size(); i++) begin
      check($sformatf("a_byte%0d", i), 32'(got[i]), 32'(exp[(13 - i) * 8 +: 8]));
    end
    if (rdy_pct == 100) check("a_cycles", 32'(iter), 32'(target));
    if (stop_after == 0) begin
      @(negedge clk);
      frame_a = fr;
      posti_a = pd;
      start_a = start_at_done;
      check("a_done", 32'(done_a), 32'd1);
      check("a_busy_end", 32'(busy_a), 32'd0);
      check("a_valid_end", 32'(ifa.tx_valid), 32'd0);
    end
  endtask

  localparam logic [111:0] PKT1 = 112'hFF01000000443322_11D0C0B0A08B;
  localparam logic [111:0] PKT2 = 112'hFF02010000040302_0108070605_27;

  initial begin
    logic [31:0] exp_b;
    ifa.tx_ready = 1'b0;
    ifb.tx_ready = 1'b1;

    @(negedge clk);
    check("rst_valid", 32'(ifa.tx_valid), 32'd0);
    check("rst_data", 32'(ifa.tx_data), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovr", 32'(ovr_a), 32'd0);
    rst = 1'b0;

    run_a(1'b1, 100, 0, 1'b0, 1'b0, 0, 32'h00000001, 64'hA0B0C0D0_11223344, PKT1);
    run_a(1'b1, 30, 0, 1'b0, 1'b0, 0, 32'h00000001, 64'hA0B0C0D0_11223344, PKT1);
    run_a(1'b1, 100, 3, 1'b1, 1'b1, 0, 32'h00000001, 64'hA0B0C0D0_11223344, PKT1);
    check("ovr4", 32'(ovr_a), 32'd4);

    run_a(1'b0, 100, 0, 1'b0, 1'b0, 6, 32'h00000001, 64'hA0B0C0D0_11223344, PKT1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(ifa.tx_valid), 32'd0);
    check("mid_rst_data", 32'(ifa.tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_done", 32'(done_a), 32'd0);
    check("mid_rst_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_a(1'b1, 100, 0, 1'b0, 1'b0, 0, 32'h00000102, 64'h05060708_01020304, PKT2);

    exp_b = 32'hFFEFBE7F;
    @(negedge clk);
    frame_b = 16'hBEEF;
    posti_b = 8'h7F;
    start_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      check($sformatf("b_valid%0d", i), 32'(ifb.tx_valid), 32'd1);
      check($sformatf("b_byte%0d", i), 32'(ifb.tx_data), 32'(exp_b[(3 - i) * 8 +: 8]));
    end
    @(negedge clk);
    check("b_done", 32'(done_b), 32'd1);
    check("b_valid_end", 32'(ifb.tx_valid), 32'd0);

    ifa.tx_ready = 1'b0;
    start_a = 1'b1;
    repeat (65535) @(negedge clk);
    check("ovr_fffe", 32'(ovr_a), 32'h0000FFFE);
    @(negedge clk);
    check("ovr_ffff", 32'(ovr_a), 32'h0000FFFF);
    repeat (5) @(negedge clk);
    check("ovr_sat", 32'(ovr_a), 32'h0000FFFF);
    check("stall_data", 32'(ifa.tx_data), 32'h000000FF);
    check("stall_valid", 32'(ifa.tx_valid), 32'd1);
    start_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
